// File: rtl/irq_pattern_gen.sv
// Multi-channel periodic interrupt generator: each channel counts to a runtime
// period and raises a pulse or level interrupt, flagging events lost behind a pending level IRQ.
module irq_pattern_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_CH-1:0]       enable_i,
  input  logic [NUM_CH*CNT_W-1:0] period_i,
  input  logic [NUM_CH-1:0]       level_mode_i,
  input  logic [NUM_CH-1:0]       ack_i,
  output logic [NUM_CH-1:0]       irq_o,
  output logic [NUM_CH-1:0]       missed_o,
  output logic                    any_irq_o
);

  logic [NUM_CH-1:0][CNT_W-1:0] period_w;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            irq_q, irq_d;
  logic [NUM_CH-1:0]            missed_q, missed_d;
  logic [NUM_CH-1:0]            event_w;

  assign period_w = period_i;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    cnt_d    = cnt_q;
    irq_d    = irq_q;
    missed_d = missed_q;
    event_w  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      // >= rather than == so a period lowered below the running count fires at once.
      event_w[ch] = enable_i[ch] && (period_w[ch] != '0) &&
                    (cnt_q[ch] >= period_w[ch] - CNT_W'(1));

      if (!enable_i[ch] || (period_w[ch] == '0) || event_w[ch]) begin
        cnt_d[ch] = '0;
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end

      if (level_mode_i[ch]) begin
        irq_d[ch] = event_w[ch] | (irq_q[ch] & ~ack_i[ch]);
      end else begin
        irq_d[ch] = event_w[ch];
      end

      if (!level_mode_i[ch] || ack_i[ch]) begin
        missed_d[ch] = 1'b0;
      end else if (irq_q[ch] && event_w[ch]) begin
        missed_d[ch] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q    <= '0;
      irq_q    <= '0;
      missed_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      cnt_q    <= cnt_d;
      irq_q    <= irq_d;
      missed_q <= missed_d;
    end
  end

  assign irq_o     = irq_q;
  assign missed_o  = missed_q;
  assign any_irq_o = |irq_q;

endmodule

// File: tb/tb_irq_pattern_gen.sv
// Directed self-checking bench for irq_pattern_gen; one task per scenario,
// expected values hand-derived from the cycle numbering (cycle 0 = first cycle with enable set).
module tb_irq_pattern_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;

  logic                    clk_i = 1'b0;
  logic                    reset_i;
  logic [NUM_CH-1:0]       enable_i;
  logic [NUM_CH*CNT_W-1:0] period_i;
  logic [NUM_CH-1:0]       level_mode_i;
  logic [NUM_CH-1:0]       ack_i;
  logic [NUM_CH-1:0]       irq_o;
  logic [NUM_CH-1:0]       missed_o;
  logic                    any_irq_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  irq_pattern_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .enable_i    (enable_i),
    .period_i    (period_i),
    .level_mode_i(level_mode_i),
    .ack_i       (ack_i),
    .irq_o       (irq_o),
    .missed_o    (missed_o),
    .any_irq_o   (any_irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one cycle; afterwards outputs show the new cycle's values and
  // inputs driven now take effect on the following edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_period(input int ch, input logic [CNT_W-1:0] p);
    period_i[ch*CNT_W +: CNT_W] = p;
  endtask

  // Leaves the DUT freshly reset with every input idle; the caller's first
  // enable is then seen in cycle 0.
  task automatic do_reset();
    enable_i     = '0;
    period_i     = '0;
    level_mode_i = '0;
    ack_i        = '0;
    reset_i      = 1'b0;
    tick();
    reset_i      = 1'b1;
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    do_reset();
    set_period(0, 10);
    level_mode_i[0] = 1'b1;
    enable_i[0]     = 1'b1;
    // Events at 9 and 19 without ack: irq from 10, missed from 20, cnt = 5 at 25.
    ticks(25);
    chk("reset_pre_irq", 25, 32'(irq_o), 32'h1);
    chk("reset_pre_missed", 25, 32'(missed_o), 32'h1);
    #2;
    reset_i = 1'b0;
    #1;
    chk("reset_async_irq", 25, 32'(irq_o), 32'h0);
    chk("reset_async_missed", 25, 32'(missed_o), 32'h0);
    chk("reset_async_any", 25, 32'(any_irq_o), 32'h0);
    enable_i = '0;
    tick();
    reset_i = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      chk("idle_outputs", c, 32'({irq_o, missed_o, any_irq_o}), 32'h0);
    end
  endtask

  task automatic test_pulse();
    logic [NUM_CH-1:0] exp;
    do_reset();
    set_period(0, 4);
    set_period(1, 1);
    set_period(2, 0);
    enable_i = 4'b0111;
    for (int c = 1; c <= 20; c++) begin
      tick();
      exp = {1'b0, 1'b0, 1'b1, ((c % 4) == 0)};
      chk("pulse_irq", c, 32'(irq_o), 32'(exp));
      chk("pulse_missed", c, 32'(missed_o), 32'h0);
    end
  endtask

  task automatic test_level_ack();
    logic exp;
    do_reset();
    set_period(0, 10);
    level_mode_i[0] = 1'b1;
    enable_i[0]     = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      tick();
      ack_i[0] = (c == 14) || (c == 29);
      exp = ((c >= 10) && (c <= 14)) || (c >= 20);
      chk("level_irq", c, 32'(irq_o[0]), 32'(exp));
      chk("level_missed", c, 32'(missed_o[0]), 32'h0);
    end
    ack_i = '0;
  endtask

  task automatic test_missed();
    do_reset();
    set_period(0, 3);
    level_mode_i[0] = 1'b1;
    enable_i[0]     = 1'b1;
    ticks(3);
    chk("missed_irq_c3", 3, 32'(irq_o[0]), 32'h1);
    chk("missed_flag_c3", 3, 32'(missed_o[0]), 32'h0);
    ticks(2);
    chk("missed_flag_c5", 5, 32'(missed_o[0]), 32'h0);
    tick();
    chk("missed_flag_c6", 6, 32'(missed_o[0]), 32'h1);
    ack_i[0] = 1'b1;
    tick();
    ack_i[0] = 1'b0;
    chk("missed_ack_irq_c7", 7, 32'(irq_o[0]), 32'h0);
    chk("missed_ack_flag_c7", 7, 32'(missed_o[0]), 32'h0);
    ticks(2);
    chk("missed_rearm_irq_c9", 9, 32'(irq_o[0]), 32'h1);
    chk("missed_rearm_flag_c9", 9, 32'(missed_o[0]), 32'h0);
  endtask

  task automatic test_period_shrink();
    logic exp;
    do_reset();
    set_period(0, 100);
    enable_i[0] = 1'b1;
    for (int c = 1; c <= 95; c++) begin
      tick();
      if (c == 50) set_period(0, 20);
      exp = (c == 51) || (c == 71) || (c == 91);
      chk("shrink_irq", c, 32'(irq_o[0]), 32'(exp));
    end
  endtask

  task automatic test_disable();
    do_reset();
    set_period(0, 5);
    level_mode_i[0] = 1'b1;
    enable_i[0]     = 1'b1;
    ticks(5);
    chk("dis_irq_c5", 5, 32'(irq_o[0]), 32'h1);
    enable_i[0] = 1'b0;
    ticks(5);
    chk("dis_held_c10", 10, 32'(irq_o[0]), 32'h1);
    chk("dis_missed_c10", 10, 32'(missed_o[0]), 32'h0);
    ack_i[0] = 1'b1;
    tick();
    ack_i[0]    = 1'b0;
    chk("dis_ack_c11", 11, 32'(irq_o[0]), 32'h0);
    // Re-enabled in cycle 11 with cnt = 0: event in 15, irq in 16.
    enable_i[0] = 1'b1;
    ticks(4);
    chk("reen_quiet_c15", 15, 32'(irq_o[0]), 32'h0);
    tick();
    chk("reen_irq_c16", 16, 32'(irq_o[0]), 32'h1);
  endtask

  task automatic test_multi_channel();
    int                per [NUM_CH];
    logic [NUM_CH-1:0] exp;
    per[0] = 3; per[1] = 5; per[2] = 7; per[3] = 11;
    do_reset();
    for (int n = 0; n < NUM_CH; n++) set_period(n, CNT_W'(per[n]));
    enable_i = '1;
    for (int c = 1; c <= 1000; c++) begin
      tick();
      for (int n = 0; n < NUM_CH; n++) exp[n] = ((c % per[n]) == 0);
      chk("multi_irq", c, 32'(irq_o), 32'(exp));
      chk("multi_any", c, 32'(any_irq_o), 32'(|exp));
    end
  endtask

  initial begin
    reset_i      = 1'b0;
    enable_i     = '0;
    period_i     = '0;
    level_mode_i = '0;
    ack_i        = '0;
    #1;
    chk("reset_state", 0, 32'({irq_o, missed_o, any_irq_o}), 32'h0);
    test_reset();
    test_pulse();
    test_level_ack();
    test_missed();
    test_period_shrink();
    test_disable();
    test_multi_channel();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
